// File: rtl/dds_spi_pkg.sv
// Shared types and frame-layout constants for the SPI-to-regfile bridge.
package dds_spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        LATCH = 3'd2,
        DATA  = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

    localparam int CNT_W      = 5;
    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 8;

    localparam logic [CNT_W-1:0] FRAME_BITS = 5'd16;
    localparam logic [CNT_W-1:0] CMD_BITS   = 5'd8;

    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 11;
    localparam int ADDR_LSB = 8;

endpackage

// File: rtl/sync_ff.sv
// Flop-chain synchronizer for one asynchronous pin; reset loads the pin's idle level.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave turning 16-bit frames into regfile write strobes and readback.
// state | meaning
// IDLE  | cs_n high, waiting for a cs_n fall
// CMD   | shifting in RW/reserved/ADDR byte
// LATCH | one cycle to capture regfile read data
// DATA  | shifting in payload, shifting out read data on sclk falls
// DONE  | frame complete, waiting for cs_n rise
module spi_reg_bridge
    import dds_spi_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic                  o_en_wr,
    output logic [REG_ADDR_W-1:0] o_addr_wr,
    output logic [REG_DATA_W-1:0] o_data,
    output logic [REG_ADDR_W-1:0] o_addr_rd,
    input  logic [REG_DATA_W-1:0] i_rd_data,
    output logic                  o_frame_err
);

    localparam logic [REG_ADDR_W:0] NUM_REGS_L = NUM_REGS[REG_ADDR_W:0];

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_state_e            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, cnt_inc;
    logic [REG_DATA_W-1:0] shift_q, shift_d, shift_in;
    logic [REG_DATA_W-1:0] rd_shift_q, rd_shift_d;
    logic                  rw_q, rw_d;
    logic                  sclk_hist_q, cs_hist_q;
    logic                  miso_q, miso_d;
    logic                  en_wr_q, en_wr_d;
    logic                  err_q, err_d;
    logic [REG_ADDR_W-1:0] addr_wr_q, addr_wr_d;
    logic [REG_ADDR_W-1:0] addr_rd_q, addr_rd_d;
    logic [REG_DATA_W-1:0] data_q, data_d;
    logic                  addr_ok;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(i_sclk), .q_o(sclk_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .rst(rst), .d_i(i_cs_n), .q_o(cs_n_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(i_mosi), .q_o(mosi_s));

    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign cs_fall   = ~cs_n_s & cs_hist_q;
    assign cs_rise   = cs_n_s & ~cs_hist_q;
    assign addr_ok   = ({1'b0, addr_rd_q} < NUM_REGS_L);
    assign shift_in  = {shift_q[REG_DATA_W-2:0], mosi_s};
    assign cnt_inc   = (bit_cnt_q == FRAME_BITS) ? bit_cnt_q : bit_cnt_q + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rd_shift_q  <= '0;
            rw_q        <= 1'b0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
            miso_q      <= 1'b0;
            en_wr_q     <= 1'b0;
            err_q       <= 1'b0;
            addr_wr_q   <= '0;
            addr_rd_q   <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rd_shift_q  <= rd_shift_d;
            rw_q        <= rw_d;
            sclk_hist_q <= sclk_s;
            cs_hist_q   <= cs_n_s;
            miso_q      <= miso_d;
            en_wr_q     <= en_wr_d;
            err_q       <= err_d;
            addr_wr_q   <= addr_wr_d;
            addr_rd_q   <= addr_rd_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rd_shift_d = rd_shift_q;
        rw_d       = rw_q;
        miso_d     = miso_q;
        en_wr_d    = 1'b0;
        err_d      = 1'b0;
        addr_wr_d  = addr_wr_q;
        addr_rd_d  = addr_rd_q;
        data_d     = data_q;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    bit_cnt_d = '0;
                    state_d   = CMD;
                end
            end
            CMD: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = cnt_inc;
                    if (cnt_inc == CMD_BITS) begin
                        addr_rd_d = shift_in[ADDR_MSB-REG_DATA_W:ADDR_LSB-REG_DATA_W];
                        rw_d      = shift_in[RW_BIT-REG_DATA_W];
                        state_d   = LATCH;
                    end
                end
            end
            LATCH: begin
                if (cs_rise) begin
                    err_d   = 1'b1;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    rd_shift_d = addr_ok ? i_rd_data : '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                // an abort wins even when it coincides with the last sclk rise
                if (cs_rise) begin
                    err_d   = 1'b1;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (sclk_fall) begin
                        miso_d     = rw_q ? 1'b0 : rd_shift_q[REG_DATA_W-1];
                        rd_shift_d = {rd_shift_q[REG_DATA_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = cnt_inc;
                        if (cnt_inc == FRAME_BITS) begin
                            if (rw_q && addr_ok) begin
                                addr_wr_d = addr_rd_q;
                                data_d    = shift_in;
                                en_wr_d   = 1'b1;
                            end else if (rw_q) begin
                                err_d = 1'b1;
                            end
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_miso      = miso_q;
    assign o_en_wr     = en_wr_q;
    assign o_addr_wr   = addr_wr_q;
    assign o_data      = data_q;
    assign o_addr_rd   = addr_rd_q;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: SPI master driver, small regfile model, pulse monitors.
module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_sclk = 1'b0;
    logic       i_cs_n = 1'b1;
    logic       i_mosi = 1'b0;
    logic       o_miso;
    logic       o_en_wr;
    logic [3:0] o_addr_wr;
    logic [7:0] o_data;
    logic [3:0] o_addr_rd;
    logic [7:0] i_rd_data;
    logic       o_frame_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] regs [8];
    int         wr_cnt  = 0;
    int         err_cnt = 0;
    logic [3:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic [15:0] rx;
    int          wr0, err0;

    spi_reg_bridge #(.NUM_REGS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
        .o_miso(o_miso), .o_en_wr(o_en_wr), .o_addr_wr(o_addr_wr), .o_data(o_data),
        .o_addr_rd(o_addr_rd), .i_rd_data(i_rd_data), .o_frame_err(o_frame_err));

    always #5 clk = ~clk;

    // out-of-range reads return 0xFF so the bridge's forced 0x00 is observable
    assign i_rd_data = o_addr_rd[3] ? 8'hFF : regs[o_addr_rd[2:0]];

    always @(posedge clk) begin
        if (o_en_wr && !o_addr_wr[3]) regs[o_addr_wr[2:0]] <= o_data;
    end

    always @(negedge clk) begin
        if (o_en_wr) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= o_addr_wr;
            last_data <= o_data;
        end
        if (o_frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: master drives MOSI while sclk low, samples MISO on the rise
    task automatic spi_xfer(input logic [15:0] tx, input int nbits, input bit end_frame,
                            output logic [15:0] rx_o);
        rx_o = '0;
        i_cs_n = 1'b0;
        #200;
        for (int i = 0; i < nbits; i++) begin
            i_mosi = (i < 16) ? tx[15-i] : 1'b0;
            #50;
            i_sclk = 1'b1;
            if (i < 16) rx_o[15-i] = o_miso;
            #50;
            i_sclk = 1'b0;
        end
        #100;
        if (end_frame) begin
            i_cs_n = 1'b1;
            #200;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i);
        regs[5] = 8'h3C;
        repeat (5) @(negedge clk);
        check("rst_miso", {31'd0, o_miso}, 32'd0);
        check("rst_en_wr", {31'd0, o_en_wr}, 32'd0);
        check("rst_addr_wr", {28'd0, o_addr_wr}, 32'd0);
        check("rst_data", {24'd0, o_data}, 32'd0);
        check("rst_addr_rd", {28'd0, o_addr_rd}, 32'd0);
        check("rst_frame_err", {31'd0, o_frame_err}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        wr0 = wr_cnt; err0 = err_cnt;
        spi_xfer(16'h83A5, 16, 1'b1, rx);
        check("wr3_strobes", 32'(wr_cnt - wr0), 32'd1);
        check("wr3_addr", {28'd0, last_addr}, 32'd3);
        check("wr3_data", {24'd0, last_data}, 32'hA5);
        check("wr3_err", 32'(err_cnt - err0), 32'd0);
        check("wr3_addr_held", {28'd0, o_addr_wr}, 32'd3);
        check("wr3_data_held", {24'd0, o_data}, 32'hA5);

        wr0 = wr_cnt; err0 = err_cnt;
        spi_xfer(16'h0500, 16, 1'b1, rx);
        check("rd5_addr_rd", {28'd0, o_addr_rd}, 32'd5);
        check("rd5_miso", {24'd0, rx[7:0]}, 32'h3C);
        check("rd5_cmd_phase_miso", {24'd0, rx[15:8]}, 32'h00);
        check("rd5_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("rd5_err", 32'(err_cnt - err0), 32'd0);

        spi_xfer(16'h0A00, 16, 1'b1, rx);
        check("rd10_miso_zero", {24'd0, rx[7:0]}, 32'h00);
        check("rd10_addr_rd", {28'd0, o_addr_rd}, 32'd10);

        wr0 = wr_cnt; err0 = err_cnt;
        spi_xfer(16'h8C11, 16, 1'b1, rx);
        check("wr12_no_strobe", 32'(wr_cnt - wr0), 32'd0);
        check("wr12_err", 32'(err_cnt - err0), 32'd1);

        wr0 = wr_cnt; err0 = err_cnt;
        spi_xfer(16'h82FF, 11, 1'b1, rx);
        check("abort_err", 32'(err_cnt - err0), 32'd1);
        check("abort_no_strobe", 32'(wr_cnt - wr0), 32'd0);
        check("abort_miso", {31'd0, o_miso}, 32'd0);

        wr0 = wr_cnt; err0 = err_cnt;
        spi_xfer(16'h8201, 16, 1'b1, rx);
        check("wr2_strobes", 32'(wr_cnt - wr0), 32'd1);
        check("wr2_addr", {28'd0, last_addr}, 32'd2);
        check("wr2_data", {24'd0, last_data}, 32'h01);
        check("wr2_regfile", {24'd0, regs[2]}, 32'h01);

        wr0 = wr_cnt; err0 = err_cnt;
        spi_xfer(16'h8155, 20, 1'b1, rx);
        check("wr1_long_strobes", 32'(wr_cnt - wr0), 32'd1);
        check("wr1_long_addr", {28'd0, last_addr}, 32'd1);
        check("wr1_long_data", {24'd0, last_data}, 32'h55);
        check("wr1_long_err", 32'(err_cnt - err0), 32'd0);

        wr0 = wr_cnt; err0 = err_cnt;
        spi_xfer(16'h8777, 12, 1'b0, rx);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_addr_wr", {28'd0, o_addr_wr}, 32'd0);
        check("midrst_data", {24'd0, o_data}, 32'd0);
        check("midrst_addr_rd", {28'd0, o_addr_rd}, 32'd0);
        check("midrst_miso", {31'd0, o_miso}, 32'd0);
        check("midrst_en_wr", {31'd0, o_en_wr}, 32'd0);
        i_cs_n = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_strobe", 32'(wr_cnt - wr0), 32'd0);
        check("midrst_regfile", {24'd0, regs[7]}, 32'h17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
